// File: rtl/io_port_ctrl_pkg.sv
// Shared constants and the hex-to-segment decode for the switch/7-segment I/O controller.
package io_port_ctrl_pkg;

  localparam logic [1:0] IO_SW_VAL  = 2'd0;
  localparam logic [1:0] IO_SW_CHG  = 2'd1;
  localparam logic [1:0] IO_HEX_VAL = 2'd2;
  localparam logic [1:0] IO_HEX_EN  = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU data-memory side of the I/O window: select, write strobe, word offset and data.
interface io_port_ctrl_if;
  logic        io_sel;
  logic        io_we;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (output io_sel, io_we, io_addr, io_wdata, input io_rdata);
  modport slave  (input io_sel, io_we, io_addr, io_wdata, output io_rdata);
endinterface

// File: rtl/io_port_ctrl_hex_to_seg7.sv
// One 7-segment digit: nibble plus enable to active-low segments, blank when disabled.
module hex_to_seg7
  import io_port_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       en,
  output logic [6:0] seg
);

  // Decode nibble or blank the digit.
  always_comb begin
    seg = SEG_BLANK;
    if (en) begin
      seg = hex_decode(nibble);
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped switch/7-segment controller: switch sync + debounce with change flags,
// hex display register with per-digit enables, registered CPU read port.
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int SW_WIDTH        = 10,
  parameter int HEX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock_50,
  input  logic                reset,
  io_port_ctrl_if.slave       bus,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic                sw_irq,
  output logic [6:0]          seg0,
  output logic [6:0]          seg1,
  output logic [6:0]          seg2,
  output logic [6:0]          seg3
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync1_r;
  logic [SW_WIDTH-1:0] sync2_r;
  logic [SW_WIDTH-1:0] prev_r;
  logic [SW_WIDTH-1:0] sw_val_r;
  logic [SW_WIDTH-1:0] sw_chg_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [15:0]         hex_val_r;
  logic [3:0]          hex_en_r;
  logic [31:0]         rdata_r;

  logic                tick_s;
  logic                rd_en_s;
  logic                wr_en_s;
  logic                chg_clear_s;
  logic [SW_WIDTH-1:0] chg_event_s;
  logic [31:0]         rd_mux_s;
  logic [6:0]          seg_s [4];
  logic                unused_wdata_s;

  assign tick_s      = (cnt_r == CNT_LAST);
  assign rd_en_s     = bus.io_sel & ~bus.io_we;
  assign wr_en_s     = bus.io_sel & bus.io_we;
  assign chg_clear_s = rd_en_s & (bus.io_addr == IO_SW_CHG);
  // A switch moves only when two consecutive tick samples agree and differ from the held value.
  assign chg_event_s = {SW_WIDTH{tick_s}} & ~(sync2_r ^ prev_r) & (sync2_r ^ sw_val_r);
  assign unused_wdata_s = &{1'b0, bus.io_wdata[31:16]};

  // Two-flop synchronizer for the raw switch levels.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
    end
  end

  // Free-running debounce prescaler.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Debounced value, previous tick sample and sticky change flags (new events beat a read-clear).
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      prev_r   <= '0;
      sw_val_r <= '0;
      sw_chg_r <= '0;
    end else begin
      if (tick_s) begin
        prev_r <= sync2_r;
      end
      sw_val_r <= sw_val_r ^ chg_event_s;
      if (chg_clear_s) begin
        sw_chg_r <= chg_event_s;
      end else begin
        sw_chg_r <= sw_chg_r | chg_event_s;
      end
    end
  end

  // Display value and digit-enable registers.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      hex_val_r <= 16'h0000;
      hex_en_r  <= 4'hF;
    end else if (wr_en_s && bus.io_addr == IO_HEX_VAL) begin
      hex_val_r <= bus.io_wdata[15:0];
    end else if (wr_en_s && bus.io_addr == IO_HEX_EN) begin
      hex_en_r  <= bus.io_wdata[3:0];
    end
  end

  // Read data select.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.io_addr)
      IO_SW_VAL:  rd_mux_s = {{(32-SW_WIDTH){1'b0}}, sw_val_r};
      IO_SW_CHG:  rd_mux_s = {{(32-SW_WIDTH){1'b0}}, sw_chg_r};
      IO_HEX_VAL: rd_mux_s = {16'h0000, hex_val_r};
      IO_HEX_EN:  rd_mux_s = {28'h0000000, hex_en_r};
      default:    rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Registered load data, held between reads.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_en_s) begin
      rdata_r <= rd_mux_s;
    end
  end

  assign bus.io_rdata = rdata_r;
  assign sw_irq       = |sw_chg_r;

  for (genvar d = 0; d < 4; d++) begin : g_digit
    hex_to_seg7 u_seg (
      .nibble (hex_val_r[4*d +: 4]),
      .en     (hex_en_r[d]),
      .seg    (seg_s[d])
    );
  end

  assign seg0 = seg_s[0];
  assign seg1 = seg_s[1];
  assign seg2 = seg_s[2];
  assign seg3 = seg_s[3];

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl with a 4-cycle debounce tick.
module tb_io_port_ctrl;
  import io_port_ctrl_pkg::*;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  logic       clk;
  logic       rst;
  logic [9:0] sw_in;
  logic       sw_irq;
  logic [6:0] seg0, seg1, seg2, seg3;
  int         tests;
  int         fails;
  int         ec;
  rd_exp_t    exp_q[$];

  io_port_ctrl_if bus ();

  io_port_ctrl #(.SW_WIDTH(10), .HEX_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock_50 (clk),
    .reset    (rst),
    .bus      (bus),
    .sw_in    (sw_in),
    .sw_irq   (sw_irq),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; edges with ec % 4 == 0 are debounce ticks.
  always @(posedge clk or posedge rst) begin
    if (rst) ec <= 0;
    else     ec <= ec + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_read(input logic [1:0] addr, input logic [31:0] exp);
    rd_exp_t e;
    @(negedge clk);
    e.addr = addr;
    e.data = exp;
    exp_q.push_back(e);
    bus.io_sel = 1'b1; bus.io_we = 1'b0; bus.io_addr = addr;
    @(negedge clk);
    bus.io_sel = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.io_sel = 1'b1; bus.io_we = 1'b1; bus.io_addr = addr; bus.io_wdata = data;
    @(negedge clk);
    bus.io_sel = 1'b0; bus.io_we = 1'b0;
  endtask

  task automatic check_segs(input string name, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    check({name, "_seg3"}, {25'd0, seg3}, {25'd0, e3});
    check({name, "_seg2"}, {25'd0, seg2}, {25'd0, e2});
    check({name, "_seg1"}, {25'd0, seg1}, {25'd0, e1});
    check({name, "_seg0"}, {25'd0, seg0}, {25'd0, e0});
  endtask

  // Monitor: a read accepted at an edge presents its data until the next edge.
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (bus.io_sel === 1'b1 && bus.io_we === 1'b0 && rst === 1'b0) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("rd_unexpected", bus.io_rdata, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rd_addr%0d", e.addr), bus.io_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; sw_in = 10'h000;
    bus.io_sel = 1'b0; bus.io_we = 1'b0; bus.io_addr = 2'd0; bus.io_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.io_rdata, 32'h0);
    check("rst_irq", {31'd0, sw_irq}, 32'h0);
    check_segs("rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    rst = 1'b0;
    cpu_read(IO_HEX_EN, 32'h0000_000F);
    cpu_read(IO_HEX_VAL, 32'h0);
    cpu_read(IO_SW_VAL, 32'h0);

    // Debounce of switch 0
    @(negedge clk); sw_in = 10'h001;
    repeat (12) @(negedge clk);
    cpu_read(IO_SW_VAL, 32'h001);
    check("deb_irq_set", {31'd0, sw_irq}, 32'h1);
    cpu_read(IO_SW_CHG, 32'h001);
    cpu_read(IO_SW_CHG, 32'h000);
    check("deb_irq_clr", {31'd0, sw_irq}, 32'h0);

    // Two-cycle glitch on switch 3
    @(negedge clk); sw_in[3] = 1'b1;
    @(negedge clk);
    @(negedge clk); sw_in[3] = 1'b0;
    repeat (12) @(negedge clk);
    cpu_read(IO_SW_VAL, 32'h001);
    cpu_read(IO_SW_CHG, 32'h000);
    check("glitch_irq", {31'd0, sw_irq}, 32'h0);

    // Collision: read-clear lands on the edge where switch 5 debounces
    @(negedge clk); sw_in[1] = 1'b1;
    repeat (12) @(negedge clk);
    check("col_irq_pre", {31'd0, sw_irq}, 32'h1);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ec % 4 == 0) break;
    end
    @(negedge clk); sw_in[5] = 1'b1;
    repeat (7) @(posedge clk);
    cpu_read(IO_SW_CHG, 32'h002);
    check("col_irq_post", {31'd0, sw_irq}, 32'h1);
    cpu_read(IO_SW_CHG, 32'h020);
    cpu_read(IO_SW_VAL, 32'h023);
    cpu_write(IO_SW_VAL, 32'h0000_03FF);
    cpu_write(IO_SW_CHG, 32'h0000_03FF);
    cpu_read(IO_SW_CHG, 32'h000);
    cpu_read(IO_SW_VAL, 32'h023);

    // Display and blanking
    cpu_write(IO_HEX_VAL, 32'hFFFF_12AF);
    check_segs("disp", 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110);
    cpu_read(IO_HEX_VAL, 32'h0000_12AF);
    cpu_write(IO_HEX_EN, 32'hFFFF_FFF5);
    check_segs("blank", 7'h7F, 7'b0100100, 7'h7F, 7'b0001110);
    cpu_read(IO_HEX_EN, 32'h0000_0005);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-cycle
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_rdata", bus.io_rdata, 32'h0);
    check("mid_rst_irq", {31'd0, sw_irq}, 32'h0);
    check_segs("mid_rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    @(negedge clk); rst = 1'b0;
    cpu_read(IO_SW_VAL, 32'h0);
    cpu_read(IO_HEX_EN, 32'h0000_000F);
    cpu_read(IO_HEX_VAL, 32'h0);
    repeat (12) @(negedge clk);
    cpu_read(IO_SW_VAL, 32'h023);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
